// File: rtl/apb_nslave_bridge_pkg.sv
// -----------------------------------------------------------------------------
// apb_nslave_bridge_pkg
//   Shared definitions for the APB requester/decoder slice. Other APB masters
//   and slaves reuse these definitions.
//   - apb_state_e : requester sequencing states (IDLE/SETUP/ACCESS/DERR)
//   - sel_bits()  : width of the slave index field, never less than 1
//   - to_bits()   : width of a counter that can hold 0..timeout_cycles
// -----------------------------------------------------------------------------
package apb_nslave_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DERR   = 2'd3
  } apb_state_e;

  function automatic int sel_bits(input int slave_num);
    return (slave_num > 1) ? $clog2(slave_num) : 1;
  endfunction

  function automatic int to_bits(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// -----------------------------------------------------------------------------
// apb_addr_decode
//   Combinational slave decode. The slave index is taken from the top SEL_BITS
//   bits of the address; an index at or above SLAVE_NUM is unmapped.
//   Ports:
//     ADDR  in  request address
//     idx   out slave index (top address bits)
//     hit   out 1 when idx selects an existing slave
// -----------------------------------------------------------------------------
module apb_addr_decode
  import apb_nslave_bridge_pkg::*;
#(
  parameter  int MAIN_ADDR_WIDTH = 32,
  parameter  int SLAVE_NUM       = 4,
  localparam int SEL_BITS        = sel_bits(SLAVE_NUM)
) (
  input  logic [MAIN_ADDR_WIDTH-1:0] ADDR,
  output logic [SEL_BITS-1:0]        idx,
  output logic                       hit
);

  // One extra bit so SLAVE_NUM itself is representable for the compare.
  localparam logic [SEL_BITS:0] NUM_SLAVES = (SEL_BITS + 1)'(SLAVE_NUM);

  assign idx = ADDR[MAIN_ADDR_WIDTH-1 -: SEL_BITS];
  assign hit = ({1'b0, idx} < NUM_SLAVES);

  // Low address bits only matter to the slaves, not to the decode.
  generate
    if (MAIN_ADDR_WIDTH > SEL_BITS) begin : g_low_bits
      logic unused_low_addr;
      assign unused_low_addr = ^ADDR[MAIN_ADDR_WIDTH-SEL_BITS-1:0];
    end
  endgenerate

endmodule

// File: rtl/apb_nslave_bridge.sv
// -----------------------------------------------------------------------------
// apb_nslave_bridge
//   APB4 requester driving SLAVE_NUM slaves on a shared address/data bus with a
//   one-hot PSEL. Level requests are sequenced IDLE -> SETUP -> ACCESS; results
//   come back as a one-cycle READY pulse with RDATA and an ERROR flag covering
//   slave errors, unmapped addresses and PREADY timeouts.
//   Ports:
//     PCLK, PRESET_n            clock, asynchronous active-low reset
//     transfer/WRITE/ADDR/WDATA/STRB   request, sampled only in IDLE
//     RDATA/READY/ERROR         completion result (registered)
//     PADDR/PSEL/PENABLE/PWRITE/PWDATA/PSTRB   APB request bus
//     PREADY_vec/PRDATA_vec/PSLVERR_vec        per-slave responses
// -----------------------------------------------------------------------------
module apb_nslave_bridge
  import apb_nslave_bridge_pkg::*;
#(
  parameter  int DATA_WIDTH      = 32,
  parameter  int MAIN_ADDR_WIDTH = 32,
  parameter  int SLAVE_NUM       = 4,
  parameter  int TIMEOUT_CYCLES  = 16,
  localparam int DATA_BYTE_NUM   = DATA_WIDTH / 8,
  localparam int SEL_BITS        = sel_bits(SLAVE_NUM),
  localparam int TO_BITS         = to_bits(TIMEOUT_CYCLES)
) (
  input  logic                            PCLK,
  input  logic                            PRESET_n,
  input  logic                            transfer,
  input  logic                            WRITE,
  input  logic [MAIN_ADDR_WIDTH-1:0]      ADDR,
  input  logic [DATA_WIDTH-1:0]           WDATA,
  input  logic [DATA_BYTE_NUM-1:0]        STRB,
  output logic [DATA_WIDTH-1:0]           RDATA,
  output logic                            READY,
  output logic                            ERROR,
  output logic [MAIN_ADDR_WIDTH-1:0]      PADDR,
  output logic [SLAVE_NUM-1:0]            PSEL,
  output logic                            PENABLE,
  output logic                            PWRITE,
  output logic [DATA_WIDTH-1:0]           PWDATA,
  output logic [DATA_BYTE_NUM-1:0]        PSTRB,
  input  logic [SLAVE_NUM-1:0]            PREADY_vec,
  input  logic [SLAVE_NUM*DATA_WIDTH-1:0] PRDATA_vec,
  input  logic [SLAVE_NUM-1:0]            PSLVERR_vec
);

  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_CYCLES - 1);

  apb_state_e          state_reg;
  logic [SEL_BITS-1:0] sel_reg;
  logic [TO_BITS-1:0]  cnt_reg;

  logic [SEL_BITS-1:0] dec_idx;
  logic                dec_hit;

  apb_addr_decode #(
    .MAIN_ADDR_WIDTH (MAIN_ADDR_WIDTH),
    .SLAVE_NUM       (SLAVE_NUM)
  ) u_decode (
    .ADDR (ADDR),
    .idx  (dec_idx),
    .hit  (dec_hit)
  );

  // Response mux: only the latched slave's response is ever looked at.
  logic [DATA_WIDTH-1:0] prdata_arr [SLAVE_NUM];
  for (genvar gi = 0; gi < SLAVE_NUM; gi++) begin : g_prdata
    assign prdata_arr[gi] = PRDATA_vec[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  logic                  pready_sel;
  logic                  pslverr_sel;
  logic [DATA_WIDTH-1:0] prdata_sel;

  assign pready_sel  = PREADY_vec[sel_reg];
  assign pslverr_sel = PSLVERR_vec[sel_reg];
  assign prdata_sel  = prdata_arr[sel_reg];

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state_reg <= ST_IDLE;
      sel_reg   <= '0;
      cnt_reg   <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      RDATA     <= '0;
      READY     <= 1'b0;
      ERROR     <= 1'b0;
    end else begin
      // READY/ERROR are single-cycle pulses; only completions raise them.
      READY <= 1'b0;
      ERROR <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          PSEL    <= '0;
          PENABLE <= 1'b0;
          if (transfer) begin
            PADDR   <= ADDR;
            PWRITE  <= WRITE;
            PWDATA  <= WDATA;
            PSTRB   <= WRITE ? STRB : '0;
            sel_reg <= dec_idx;
            if (dec_hit) begin
              // PSEL is registered here so it is visible throughout SETUP.
              PSEL      <= SLAVE_NUM'(1) << dec_idx;
              cnt_reg   <= '0;
              state_reg <= ST_SETUP;
            end else begin
              state_reg <= ST_DERR;
            end
          end
        end

        ST_SETUP: begin
          PENABLE   <= 1'b1;
          state_reg <= ST_ACCESS;
        end

        ST_ACCESS: begin
          // PREADY is tested first so it wins over a simultaneous timeout.
          if (pready_sel) begin
            READY     <= 1'b1;
            ERROR     <= pslverr_sel;
            if (!PWRITE) RDATA <= pslverr_sel ? '0 : prdata_sel;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            state_reg <= ST_IDLE;
          end else if (TIMEOUT_CYCLES != 0 && cnt_reg == TO_LAST) begin
            READY     <= 1'b1;
            ERROR     <= 1'b1;
            if (!PWRITE) RDATA <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        ST_DERR: begin
          READY     <= 1'b1;
          ERROR     <= 1'b1;
          if (!PWRITE) RDATA <= '0;
          state_reg <= ST_IDLE;
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_nslave_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_nslave_bridge
//   Directed bench for apb_nslave_bridge with three slave models
//   (configurable wait states, read data, error, never-ready).
// -----------------------------------------------------------------------------
module tb_apb_nslave_bridge;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SN = 3;
  localparam int TO = 4;
  localparam int BN = DW / 8;

  logic            PCLK;
  logic            PRESET_n;
  logic            transfer;
  logic            WRITE;
  logic [AW-1:0]   ADDR;
  logic [DW-1:0]   WDATA;
  logic [BN-1:0]   STRB;
  logic [DW-1:0]   RDATA;
  logic            READY;
  logic            ERROR;
  logic [AW-1:0]   PADDR;
  logic [SN-1:0]   PSEL;
  logic            PENABLE;
  logic            PWRITE;
  logic [DW-1:0]   PWDATA;
  logic [BN-1:0]   PSTRB;
  logic [SN-1:0]   PREADY_vec;
  logic [SN*DW-1:0] PRDATA_vec;
  logic [SN-1:0]   PSLVERR_vec;

  apb_nslave_bridge #(
    .DATA_WIDTH      (DW),
    .MAIN_ADDR_WIDTH (AW),
    .SLAVE_NUM       (SN),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .PCLK        (PCLK),
    .PRESET_n    (PRESET_n),
    .transfer    (transfer),
    .WRITE       (WRITE),
    .ADDR        (ADDR),
    .WDATA       (WDATA),
    .STRB        (STRB),
    .RDATA       (RDATA),
    .READY       (READY),
    .ERROR       (ERROR),
    .PADDR       (PADDR),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PSTRB       (PSTRB),
    .PREADY_vec  (PREADY_vec),
    .PRDATA_vec  (PRDATA_vec),
    .PSLVERR_vec (PSLVERR_vec)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // ---------------- slave models ----------------
  int          wait_cfg  [SN];
  logic [DW-1:0] rdata_cfg [SN];
  logic        err_cfg   [SN];
  logic        hang_cfg  [SN];
  int          acc_cnt;

  // Unselected slaves drive ready/error/junk so any misrouting shows up.
  always_comb begin
    logic rdy;
    PREADY_vec  = '0;
    PSLVERR_vec = '0;
    PRDATA_vec  = '0;
    for (int i = 0; i < SN; i++) begin
      if (PSEL[i]) begin
        rdy = PENABLE && !hang_cfg[i] && (acc_cnt >= wait_cfg[i]);
        PREADY_vec[i]          = rdy;
        PSLVERR_vec[i]         = rdy && err_cfg[i];
        PRDATA_vec[i*DW +: DW] = rdata_cfg[i];
      end else begin
        PREADY_vec[i]          = 1'b1;
        PSLVERR_vec[i]         = 1'b1;
        PRDATA_vec[i*DW +: DW] = 32'hBAD0_0000 | DW'(i);
      end
    end
  end

  always @(posedge PCLK) begin
    if (PENABLE && !(|(PREADY_vec & PSEL))) acc_cnt <= acc_cnt + 1;
    else                                    acc_cnt <= 0;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int acc_seen = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge PCLK);
    cyc++;
    if (PENABLE) acc_seen++;
  endtask

  // Called at a negedge; the following posedge is the accept edge (cycle 0).
  task automatic issue(input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [BN-1:0] st);
    transfer = 1'b1;
    WRITE    = wr;
    ADDR     = a;
    WDATA    = wd;
    STRB     = st;
    cyc      = 0;
    acc_seen = 0;
  endtask

  task automatic wait_ready(input int max_cyc);
    while (READY !== 1'b1 && cyc < max_cyc) step();
  endtask

  task automatic note(input string name);
    $display("xfer %-10s lat=%0d ready=%0b error=%0b rdata=%08h psel=%03b",
             name, cyc, READY, ERROR, RDATA, PSEL);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < SN; i++) begin
      wait_cfg[i]  = 0;
      rdata_cfg[i] = 32'h0;
      err_cfg[i]   = 1'b0;
      hang_cfg[i]  = 1'b0;
    end
    rdata_cfg[0] = 32'h1234_5678;
    rdata_cfg[1] = 32'hCAFE_F00D;
    rdata_cfg[2] = 32'h5A5A_5A5A;
    PRESET_n = 1'b0;
    transfer = 1'b1;
    WRITE    = 1'b1;
    ADDR     = 32'h4000_0000;
    WDATA    = 32'hFFFF_FFFF;
    STRB     = 4'hF;

    // ---- reset state ----
    repeat (2) @(negedge PCLK);
    check("rst_psel",    PSEL,    3'b000);
    check("rst_penable", PENABLE, 1'b0);
    check("rst_ready",   READY,   1'b0);
    check("rst_error",   ERROR,   1'b0);
    check("rst_paddr",   PADDR,   32'h0);
    check("rst_pwdata",  PWDATA,  32'h0);
    transfer = 1'b0;
    PRESET_n = 1'b1;
    @(negedge PCLK);

    // ---- T1: zero-wait write to slave 1 ----
    issue(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF);
    step(); transfer = 1'b0;
    check("t1_c1_psel",    PSEL,    3'b010);
    check("t1_c1_penable", PENABLE, 1'b0);
    check("t1_c1_paddr",   PADDR,   32'h4000_0010);
    check("t1_c1_pwrite",  PWRITE,  1'b1);
    check("t1_c1_pwdata",  PWDATA,  32'hDEAD_BEEF);
    check("t1_c1_pstrb",   PSTRB,   4'hF);
    step();
    check("t1_c2_psel",    PSEL,    3'b010);
    check("t1_c2_penable", PENABLE, 1'b1);
    check("t1_c2_pwdata",  PWDATA,  32'hDEAD_BEEF);
    check("t1_c2_pstrb",   PSTRB,   4'hF);
    step();
    note("t1_write");
    check("t1_c3_ready",   READY,   1'b1);
    check("t1_c3_error",   ERROR,   1'b0);
    check("t1_c3_psel",    PSEL,    3'b000);
    step();
    check("t1_c4_ready",   READY,   1'b0);
    check("t1_c4_pwdata",  PWDATA,  32'hDEAD_BEEF);

    // ---- T2: read slave 0 with 2 wait states (STRB forced to 0) ----
    wait_cfg[0] = 2;
    issue(1'b0, 32'h0000_0004, 32'h0, 4'hF);
    step(); transfer = 1'b0;
    check("t2_c1_psel",  PSEL,   3'b001);
    check("t2_c1_pstrb", PSTRB,  4'h0);
    check("t2_c1_pwrite", PWRITE, 1'b0);
    wait_ready(20);
    note("t2_read");
    check("t2_latency", cyc,   5);
    check("t2_ready",   READY, 1'b1);
    check("t2_error",   ERROR, 1'b0);
    check("t2_rdata",   RDATA, 32'h1234_5678);
    check("t2_pstrb",   PSTRB, 4'h0);
    step();
    wait_cfg[0] = 0;

    // ---- T3: unmapped read (idx 3) ----
    issue(1'b0, 32'hC000_0000, 32'h0, 4'h0);
    step(); transfer = 1'b0;
    check("t3_c1_psel", PSEL, 3'b000);
    wait_ready(20);
    note("t3_derr");
    check("t3_latency", cyc,   2);
    check("t3_error",   ERROR, 1'b1);
    check("t3_rdata",   RDATA, 32'h0);
    check("t3_psel",    PSEL,  3'b000);
    step();
    check("t3_error_clr", ERROR, 1'b0);

    // ---- T4: zero-wait read slave 1, then write to slave 0 keeps RDATA ----
    issue(1'b0, 32'h4000_0020, 32'h0, 4'h0);
    step(); transfer = 1'b0;
    wait_ready(20);
    note("t4_read");
    check("t4_latency", cyc,   3);
    check("t4_rdata",   RDATA, 32'hCAFE_F00D);
    step();
    issue(1'b1, 32'h0000_0100, 32'h0BAD_F00D, 4'h3);
    step(); transfer = 1'b0;
    check("t4w_pstrb", PSTRB, 4'h3);
    wait_ready(20);
    note("t4_write");
    check("t4w_latency", cyc,   3);
    check("t4w_rdata",   RDATA, 32'hCAFE_F00D);
    step();

    // ---- T5: slave 2 never ready -> timeout ----
    hang_cfg[2] = 1'b1;
    issue(1'b0, 32'h8000_0000, 32'h0, 4'h0);
    step(); transfer = 1'b0;
    check("t5_c1_psel", PSEL, 3'b100);
    wait_ready(20);
    note("t5_timeout");
    check("t5_latency",  cyc,      6);
    check("t5_accesses", acc_seen, TO);
    check("t5_error",    ERROR,    1'b1);
    check("t5_rdata",    RDATA,    32'h0);
    check("t5_psel",     PSEL,     3'b000);
    step();
    hang_cfg[2] = 1'b0;

    // ---- T6: slave error on read, back-to-back second request ----
    rdata_cfg[0] = 32'h1357_9BDF;
    err_cfg[1] = 1'b1;
    issue(1'b0, 32'h4000_0008, 32'h0, 4'h0);
    wait_ready(20);
    note("t6_slverr");
    check("t6_latency", cyc,   3);
    check("t6_error",   ERROR, 1'b1);
    check("t6_rdata",   RDATA, 32'h0);
    // transfer still high: new request accepted in the READY cycle
    issue(1'b0, 32'h0000_0000, 32'h0, 4'h0);
    step(); transfer = 1'b0;
    check("t6b_c1_psel",    PSEL,    3'b001);
    check("t6b_c1_penable", PENABLE, 1'b0);
    check("t6b_c1_ready",   READY,   1'b0);
    wait_ready(20);
    note("t6_b2b");
    check("t6b_latency", cyc,   3);
    check("t6b_error",   ERROR, 1'b0);
    check("t6b_rdata",   RDATA, 32'h1357_9BDF);
    step();
    err_cfg[1] = 1'b0;

    // ---- T7: asynchronous reset during ACCESS ----
    wait_cfg[0] = 1;
    issue(1'b0, 32'h0000_0004, 32'h5555_AAAA, 4'h0);
    step(); transfer = 1'b0;
    step();
    check("t7_in_access", PENABLE, 1'b1);
    #2 PRESET_n = 1'b0;
    #1;
    check("t7_psel",    PSEL,    3'b000);
    check("t7_penable", PENABLE, 1'b0);
    check("t7_paddr",   PADDR,   32'h0);
    check("t7_pwdata",  PWDATA,  32'h0);
    check("t7_rdata",   RDATA,   32'h0);
    check("t7_ready",   READY,   1'b0);
    @(negedge PCLK);
    PRESET_n = 1'b1;
    $display("xfer %-10s reset asserted mid-access", "t7_reset");
    wait_cfg[0] = 0;
    @(negedge PCLK);
    issue(1'b0, 32'h0000_0004, 32'h0, 4'h0);
    step(); transfer = 1'b0;
    wait_ready(20);
    note("t7_read");
    check("t7r_latency", cyc,   3);
    check("t7r_rdata",   RDATA, 32'h1357_9BDF);
    check("t7r_error",   ERROR, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_nslave_bridge.md
Name: apb_nslave_bridge

Overview:
- Parametrised APB4 requester with an integrated N-way slave decode and response mux, for N = SLAVE_NUM slaves.
- Accepts simple level requests from higher logic and runs IDLE/SETUP/ACCESS sequencing on a shared PADDR/PWDATA bus with a one-hot PSEL.
- Returns read data, a completion pulse and an error flag.
- Extends the existing two-slave arrangement with: arbitrary slave count, PSLVERR propagation, decode-error handling for unmapped addresses, and a programmable PREADY timeout.

Parameters:
- DATA_WIDTH, 32, PWDATA/PRDATA width; multiple of 8.
- MAIN_ADDR_WIDTH, 32, address width.
- SLAVE_NUM, 4, number of slaves; 1..16.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without PREADY before abort; 0 disables the timeout.

Derived localparams:
- DATA_BYTE_NUM = DATA_WIDTH/8.
- SEL_BITS = max(1, $clog2(SLAVE_NUM)).
- TO_BITS = max(1, $clog2(TIMEOUT_CYCLES+1)).

Ports:
- PCLK  in  1  clock; the single clock for the block.
- PRESET_n  in  1  reset, asynchronous, active-low.
- transfer  in  1  request; sampled only in IDLE.
- WRITE  in  1  1 = write, 0 = read.
- ADDR  in  MAIN_ADDR_WIDTH  request address.
- WDATA  in  DATA_WIDTH  write data.
- STRB  in  DATA_BYTE_NUM  write byte strobes.
- RDATA  out  DATA_WIDTH  read data; valid while READY=1.
- READY  out  1  one-cycle completion pulse.
- ERROR  out  1  qualified by READY: slave error, decode error or timeout.
- PADDR  out  MAIN_ADDR_WIDTH  APB address.
- PSEL  out  SLAVE_NUM  one-hot slave select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSTRB  out  DATA_BYTE_NUM  APB strobes.
- PREADY_vec  in  SLAVE_NUM  per-slave PREADY.
- PRDATA_vec  in  SLAVE_NUM*DATA_WIDTH  concatenated PRDATA; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- PSLVERR_vec  in  SLAVE_NUM  per-slave PSLVERR.

Behaviour:
- Reset (asynchronous, any state, including mid-transfer):
  - state = IDLE.
  - All outputs 0: PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, RDATA, READY, ERROR.
  - Timeout counter = 0.
- Decode:
  - idx = ADDR[MAIN_ADDR_WIDTH-1 -: SEL_BITS].
  - The address is mapped iff idx < SLAVE_NUM.
- IDLE:
  - PSEL = 0, PENABLE = 0.
  - If transfer=1, capture ADDR, WRITE, WDATA, STRB and idx into PADDR, PWRITE, PWDATA, PSTRB and sel_q.
  - PSTRB is forced to 0 when WRITE=0.
  - Go to SETUP if mapped, otherwise go to DERR.
  - Acceptance is allowed in the same cycle READY is high, so back-to-back requests are supported. Higher logic must drop transfer on READY unless it is issuing a new request.
- SETUP (1 cycle): PSEL[sel_q] = 1, PENABLE = 0; go to ACCESS.
- ACCESS:
  - PSEL[sel_q] = 1, PENABLE = 1.
  - If PREADY_vec[sel_q] = 1, complete:
    - ERROR <= PSLVERR_vec[sel_q].
    - On a read, RDATA <= selected PRDATA, or 0 if PSLVERR.
    - Go to IDLE.
  - Otherwise, if TIMEOUT_CYCLES != 0 and cnt == TIMEOUT_CYCLES-1, abort:
    - ERROR <= 1; RDATA <= 0 on a read.
    - Go to IDLE.
  - Otherwise cnt++ and stay in ACCESS.
  - cnt clears on entry to SETUP.
- DERR (1 cycle, no PSEL): ERROR <= 1, RDATA <= 0 on a read; go to IDLE.
- READY:
  - Registered; 1 in exactly the first IDLE cycle after a completion, otherwise 0.
  - ERROR is 0 whenever READY=0.
  - RDATA holds its value on write completions.
- Latency, accept cycle to READY:
  - Zero-wait slave: 3 cycles.
  - w wait states: 3+w cycles.
  - Decode error: 2 cycles.
  - Timeout: 2+TIMEOUT_CYCLES cycles.
- Bus stability: PADDR, PWRITE, PWDATA and PSTRB hold from SETUP through ACCESS and remain held in IDLE until the next accept.
- PRDATA_vec, PREADY_vec and PSLVERR_vec of unselected slaves are ignored.
- PREADY arriving on the same cycle the timeout fires: the PREADY completion wins.

Decomposition:
- Shared package/include apb_defines.vh:
  - State encodings IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, DERR=2'd3.
  - Macro/function for SEL_BITS.
  - Reused by the other APB masters and slaves.
- One combinational sub-module: apb_addr_decode.
  - Parameters MAIN_ADDR_WIDTH and SLAVE_NUM.
  - Input ADDR; outputs idx[SEL_BITS] and hit.
- The response mux stays inline in the bridge.

Test Plan:
- Setup SLAVE_NUM=3, TIMEOUT_CYCLES=4, 32-bit widths; slave models have configurable wait states.
- Write ADDR=0x4000_0010, WDATA=0xDEAD_BEEF, STRB=4'hF to a zero-wait slave -> PSEL=3'b010 with PENABLE=0 at cycle 1, PENABLE=1 at cycle 2; READY=1, ERROR=0 at cycle 3; PWDATA/PSTRB stable across both cycles.
- Read ADDR=0x0000_0004 from slave 0 with 2 wait states and PRDATA=0x1234_5678 -> READY at cycle 5, RDATA=0x1234_5678; PSTRB=0 throughout.
- Read ADDR=0xC000_0000 (idx 3, unmapped) -> PSEL stays 0, READY=1, ERROR=1, RDATA=0 at cycle 2.
- Slave 2 never asserts PREADY -> 4 ACCESS cycles, then READY=1, ERROR=1 at cycle 6, PSEL returns to 0.
- Slave 1 PREADY=1 with PSLVERR=1 on a read -> ERROR=1, RDATA=0. Hold transfer high through READY -> a second transfer is accepted in the READY cycle, back-to-back, with no idle gap.
- Deassert PRESET_n during ACCESS with one wait state -> all outputs 0 immediately and asynchronously. After release, a new read completes normally in 3 cycles.
